rx_byte_sync: RTL

RX_BYTE_SYNC -- requirements
Module: rx_byte_sync

---
 rtl/phy_pkg.sv | 27 ++
 rtl/rx_byte_sync.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/phy_pkg.sv
// ----------------------------------------------------------------------------
// phy_pkg
//   Definitions shared by the PHY receive and transmit sides:
//     - sync_state_t : byte-alignment FSM state encoding
//                      (SEARCH=0, ALIGN=1, LOCKED=2)
//     - PHY_COM_BYTE : default comma / alignment character
//     - PHY_IDL_BYTE : default idle filler character
//     - sat_inc4     : 4-bit increment that stops at a given limit
// ----------------------------------------------------------------------------
package phy_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam logic [7:0] PHY_COM_BYTE = 8'hBC;
    localparam logic [7:0] PHY_IDL_BYTE = 8'h7C;

    // Increment v by one but never past lim, so a counter cannot wrap.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v,
                                            input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/rx_byte_sync.sv
// ----------------------------------------------------------------------------
// rx_byte_sync
//   Byte-alignment / link-lock stage between the serial-to-parallel converter
//   and the 1:2 demux. It hunts for a run of LOCK_COUNT consecutive comma
//   bytes, declares the link active, and then forwards every byte that is
//   neither comma nor idle as payload with one cycle of latency. LOSS_COUNT
//   consecutive cycles without a byte strobe drop the lock.
//
// Parameters
//   COM_BYTE    comma / alignment character           (default 8'hBC)
//   IDL_BYTE    idle filler character                 (default 8'h7C)
//   LOCK_COUNT  consecutive commas needed to lock     (1..15, default 4)
//   LOSS_COUNT  consecutive strobe-less cycles to drop (1..15, default 4)
//
// Ports
//   clk_2f         in   1  byte-rate clock, rising edge
//   reset          in   1  synchronous, active-low reset
//   data_raw       in   8  byte from the serial-to-parallel stage
//   raw_valid      in   1  data_raw holds a new byte this cycle
//   data_out       out  8  payload byte (holds last payload otherwise)
//   valid_out      out  1  data_out carries a new payload byte
//   lock_lost_cnt  out  8  saturating count of lock losses
//                          (only with RX_BYTE_SYNC_ERRCNT_EN defined)
//   active         out  1  link locked
//
// Build option
//   RX_BYTE_SYNC_ERRCNT_EN  adds the lock_lost_cnt port and its register.
// ----------------------------------------------------------------------------
module rx_byte_sync
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM_BYTE   = PHY_COM_BYTE,
    parameter logic [7:0]  IDL_BYTE   = PHY_IDL_BYTE,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_raw,
    input  logic       raw_valid,
    output logic [7:0] data_out,
    output logic       valid_out,
`ifdef RX_BYTE_SYNC_ERRCNT_EN
    output logic [7:0] lock_lost_cnt,
`endif
    output logic       active
);

    localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT4 = 4'(LOSS_COUNT);

    sync_state_t state;
    sync_state_t state_nxt;
    logic [3:0]  com_cnt;
    logic [3:0]  com_nxt;
    logic [3:0]  miss_cnt;
    logic [3:0]  miss_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        is_com;
    logic        is_idl;

    assign is_com = (data_raw == COM_BYTE);
    assign is_idl = (data_raw == IDL_BYTE);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            state     <= SEARCH;
            com_cnt   <= '0;
            miss_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            com_cnt   <= com_nxt;
            miss_cnt  <= miss_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            // Registered from the next state so active rises on the very
            // edge LOCKED is entered and falls on the edge it is left.
            active    <= (state_nxt == LOCKED);
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and payload logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        com_nxt   = com_cnt;
        miss_nxt  = miss_cnt;
        data_nxt  = data_out;
        valid_nxt = 1'b0;

        case (state)
            SEARCH: begin
                if (raw_valid && is_com) begin
                    com_nxt   = 4'd1;
                    state_nxt = (LOCK_CNT4 == 4'd1) ? LOCKED : ALIGN;
                end
            end

            ALIGN: begin
                // Strobe-less cycles leave the comma run intact.
                if (raw_valid) begin
                    if (is_com) begin
                        com_nxt = sat_inc4(com_cnt, LOCK_CNT4);
                        if (com_nxt == LOCK_CNT4) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        com_nxt   = '0;
                        state_nxt = SEARCH;
                    end
                end
            end

            LOCKED: begin
                if (raw_valid) begin
                    miss_nxt = '0;
                    if (!is_com && !is_idl) begin
                        data_nxt  = data_raw;
                        valid_nxt = 1'b1;
                    end
                end else begin
                    miss_nxt = sat_inc4(miss_cnt, LOSS_CNT4);
                    if (miss_nxt == LOSS_CNT4) begin
                        // Exit only happens on a strobe-less cycle, so no
                        // payload can be in flight on the exit edge.
                        state_nxt = SEARCH;
                        com_nxt   = '0;
                        miss_nxt  = '0;
                    end
                end
            end

            default: begin
                state_nxt = SEARCH;
                com_nxt   = '0;
                miss_nxt  = '0;
            end
        endcase
    end

`ifdef RX_BYTE_SYNC_ERRCNT_EN
    // ------------------------------------------------------------------
    // Lock-loss event counter (saturating, cleared only by reset)
    // ------------------------------------------------------------------
    logic lock_drop;

    assign lock_drop = (state == LOCKED) && (state_nxt == SEARCH);

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            lock_lost_cnt <= '0;
        end else if (lock_drop && (lock_lost_cnt != 8'hFF)) begin
            lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
    end
`endif

endmodule
